// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM decode stage. It contains the instruction decoder, the
// register file and the ID/EXE pipeline register in one block.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   instr_valid, instruction, pc_in, status_nzcv, flush   decode inputs
//   wb_en_in, wb_dest, wb_value                           register write-back
//   exe_wb_en/exe_dest, mem_wb_en/mem_dest                downstream dests
//   stall_out                combinational; holds PC and IF/ID on a RAW hazard
//   out_valid .. val_rm      registered decode results for the execute stage
//
// Build option: ID_WB_BYPASS_EN forwards the write-back value to same-cycle
// register reads. Without it, a pending write-back is treated as a hazard.
module id_stage_pipe #(
    parameter int BIT_NUMBER   = 32,
    parameter int REG_NUM_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  logic [BIT_NUMBER-1:0]   instruction,
    input  logic [BIT_NUMBER-1:0]   pc_in,
    input  logic [3:0]              status_nzcv,
    input  logic                    flush,
    input  logic                    wb_en_in,
    input  logic [REG_NUM_BITS-1:0] wb_dest,
    input  logic [BIT_NUMBER-1:0]   wb_value,
    input  logic                    exe_wb_en,
    input  logic [REG_NUM_BITS-1:0] exe_dest,
    input  logic                    mem_wb_en,
    input  logic [REG_NUM_BITS-1:0] mem_dest,
    output logic                    stall_out,
    output logic                    out_valid,
    output logic                    wb_en,
    output logic                    mem_r_en,
    output logic                    mem_w_en,
    output logic                    b,
    output logic                    s,
    output logic                    imm,
    output logic [3:0]              exe_cmd,
    output logic [REG_NUM_BITS-1:0] dest,
    output logic [REG_NUM_BITS-1:0] src1,
    output logic [REG_NUM_BITS-1:0] src2,
    output logic [11:0]             shift_operand,
    output logic [23:0]             signed_imm_24,
    output logic [BIT_NUMBER-1:0]   pc,
    output logic [BIT_NUMBER-1:0]   val_rn,
    output logic [BIT_NUMBER-1:0]   val_rm
);

    localparam int REG_DEPTH = 1 << REG_NUM_BITS;

    logic [BIT_NUMBER-1:0] rf [REG_DEPTH];

    logic [3:0]              cond;
    logic [1:0]              mode;
    logic                    i_bit;
    logic [3:0]              opcode;
    logic                    s_bit;
    logic [REG_NUM_BITS-1:0] rn;
    logic [REG_NUM_BITS-1:0] rd;
    logic [REG_NUM_BITS-1:0] rm;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn     = instruction[16 +: REG_NUM_BITS];
    assign rd     = instruction[12 +: REG_NUM_BITS];
    assign rm     = instruction[0 +: REG_NUM_BITS];

    logic [3:0] dec_cmd;
    logic       dec_wb;
    logic       dec_mr;
    logic       dec_mw;
    logic       dec_b;
    logic       dec_s;
    logic       uses_rn;

    always_comb begin
        dec_cmd = '0;
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        uses_rn = 1'b1;
        case (mode)
            2'b00: begin
                dec_s = s_bit;
                case (opcode)
                    4'b1101: begin dec_cmd = 4'b0001; dec_wb = 1'b1; uses_rn = 1'b0; end
                    4'b1111: begin dec_cmd = 4'b1001; dec_wb = 1'b1; uses_rn = 1'b0; end
                    4'b0100: begin dec_cmd = 4'b0010; dec_wb = 1'b1; end
                    4'b0101: begin dec_cmd = 4'b0011; dec_wb = 1'b1; end
                    4'b0010: begin dec_cmd = 4'b0100; dec_wb = 1'b1; end
                    4'b0110: begin dec_cmd = 4'b0101; dec_wb = 1'b1; end
                    4'b0000: begin dec_cmd = 4'b0110; dec_wb = 1'b1; end
                    4'b1100: begin dec_cmd = 4'b0111; dec_wb = 1'b1; end
                    4'b0001: begin dec_cmd = 4'b1000; dec_wb = 1'b1; end
                    4'b1010: dec_cmd = 4'b0100;
                    4'b1000: dec_cmd = 4'b0110;
                    default: dec_s = 1'b0;
                endcase
            end
            2'b01: begin
                dec_cmd = 4'b0010;
                if (s_bit) begin
                    dec_mr = 1'b1;
                    dec_wb = 1'b1;
                end else begin
                    dec_mw = 1'b1;
                end
            end
            2'b10: begin
                dec_b   = 1'b1;
                uses_rn = 1'b0;
            end
            default: ;
        endcase
    end

    logic n_f, z_f, c_f, v_f;
    logic cond_pass;

    assign {n_f, z_f, c_f, v_f} = status_nzcv;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !c_f || z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f && (n_f == v_f);
            4'b1101: cond_pass = z_f || (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic [REG_NUM_BITS-1:0] src2_idx;
    logic                    two_src;
    logic                    match_rn;
    logic                    match_src2;
    logic                    wb_hit_rn;
    logic                    wb_hit_src2;
    logic                    hazard;
    logic                    load_instr;

    assign src2_idx = dec_mw ? rd : rm;
    assign two_src  = !i_bit || dec_mw;

`ifdef ID_WB_BYPASS_EN
    assign wb_hit_rn   = 1'b0;
    assign wb_hit_src2 = 1'b0;
`else
    // The register file only holds the new value after the edge, so a
    // same-cycle write-back must stall the reader for one cycle.
    assign wb_hit_rn   = wb_en_in && (wb_dest == rn);
    assign wb_hit_src2 = wb_en_in && (wb_dest == src2_idx);
`endif

    assign match_rn   = (exe_wb_en && (exe_dest == rn)) ||
                        (mem_wb_en && (mem_dest == rn)) || wb_hit_rn;
    assign match_src2 = (exe_wb_en && (exe_dest == src2_idx)) ||
                        (mem_wb_en && (mem_dest == src2_idx)) || wb_hit_src2;

    assign hazard     = instr_valid && ((uses_rn && match_rn) || (two_src && match_src2));
    assign stall_out  = hazard && !flush;
    assign load_instr = !flush && !hazard && instr_valid && cond_pass;

    logic [BIT_NUMBER-1:0] rd_rn;
    logic [BIT_NUMBER-1:0] rd_src2;

`ifdef ID_WB_BYPASS_EN
    assign rd_rn   = (wb_en_in && (wb_dest == rn))       ? wb_value : rf[rn];
    assign rd_src2 = (wb_en_in && (wb_dest == src2_idx)) ? wb_value : rf[src2_idx];
`else
    assign rd_rn   = rf[rn];
    assign rd_src2 = rf[src2_idx];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en_in) begin
            rf[wb_dest] <= wb_value;
        end
    end

    // Bubbles load every field as zero, not just the control bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || !load_instr) begin
            out_valid     <= 1'b0;
            wb_en         <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            imm           <= 1'b0;
            exe_cmd       <= '0;
            dest          <= '0;
            src1          <= '0;
            src2          <= '0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            pc            <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
        end else begin
            out_valid     <= 1'b1;
            wb_en         <= dec_wb;
            mem_r_en      <= dec_mr;
            mem_w_en      <= dec_mw;
            b             <= dec_b;
            s             <= dec_s;
            imm           <= i_bit;
            exe_cmd       <= dec_cmd;
            dest          <= rd;
            src1          <= rn;
            src2          <= src2_idx;
            shift_operand <= instruction[11:0];
            signed_imm_24 <= instruction[23:0];
            pc            <= pc_in;
            val_rn        <= rd_rn;
            val_rm        <= rd_src2;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed and randomized checks of id_stage_pipe against a
// behavioural model of the ARM decode rules kept in this file.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] pc_in = '0;
    logic [3:0]  status_nzcv = '0;
    logic        flush = 1'b0;
    logic        wb_en_in = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic        exe_wb_en = 1'b0;
    logic [3:0]  exe_dest = '0;
    logic        mem_wb_en = 1'b0;
    logic [3:0]  mem_dest = '0;

    logic        stall_out, out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  exe_cmd, dest, src1, src2;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [31:0] pc, val_rn, val_rm;

    id_stage_pipe #(.BIT_NUMBER(32), .REG_NUM_BITS(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
        .pc_in(pc_in), .status_nzcv(status_nzcv), .flush(flush),
        .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .stall_out(stall_out), .out_valid(out_valid), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s), .imm(imm),
        .exe_cmd(exe_cmd), .dest(dest), .src1(src1), .src2(src2),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
        .pc(pc), .val_rn(val_rn), .val_rm(val_rm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [16];
    logic [3:0]  cmd_tbl [16];
    bit          wb_tbl [16];
    bit          known_tbl [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [3:0] idx);
`ifdef ID_WB_BYPASS_EN
        if (wb_en_in && wb_dest == idx) return wb_value;
`endif
        return regs[idx];
    endfunction

    // One clock: predict from the current inputs, check stall_out before the
    // edge and the registered outputs after it, then commit the write-back.
    task automatic cycle();
        bit          busy [16];
        logic [1:0]  md;
        logic [3:0]  opc, rn_i, rd_i, rm_i, sec;
        bit          sb, ib, store, reads_rn, uses2, hz, issue;
        logic [3:0]  e_cmd;
        bit          e_wb, e_mr, e_mw, e_b, e_s;
        logic [31:0] e_vrn, e_vrm;

        foreach (busy[k]) busy[k] = 1'b0;
        if (exe_wb_en) busy[exe_dest] = 1'b1;
        if (mem_wb_en) busy[mem_dest] = 1'b1;
`ifndef ID_WB_BYPASS_EN
        if (wb_en_in) busy[wb_dest] = 1'b1;
`endif
        md = instruction[27:26]; opc = instruction[24:21];
        sb = instruction[20]; ib = instruction[25];
        rn_i = instruction[19:16]; rd_i = instruction[15:12]; rm_i = instruction[3:0];
        store = (md == 2'd1) && !sb;
        sec = store ? rd_i : rm_i;
        reads_rn = (md != 2'd2) && !(md == 2'd0 && (opc == 4'd13 || opc == 4'd15));
        uses2 = !ib || store;
        hz = instr_valid && ((reads_rn && busy[rn_i]) || (uses2 && busy[sec]));
        issue = !flush && !hz && instr_valid && cond_ok(instruction[31:28], status_nzcv);

        e_cmd = 4'd0; e_wb = 0; e_mr = 0; e_mw = 0; e_b = 0; e_s = 0;
        if (md == 2'd0) begin
            e_cmd = cmd_tbl[opc]; e_wb = wb_tbl[opc]; e_s = known_tbl[opc] && sb;
        end else if (md == 2'd1) begin
            e_cmd = 4'd2; e_mr = sb; e_wb = sb; e_mw = !sb;
        end else if (md == 2'd2) begin
            e_b = 1'b1;
        end
        e_vrn = read_reg(rn_i);
        e_vrm = read_reg(sec);

        #1 check("stall_out", stall_out, hz && !flush);
        @(posedge clk);
        if (wb_en_in) regs[wb_dest] = wb_value;
        #1;
        check("out_valid", out_valid, issue);
        check("wb_en", wb_en, issue && e_wb);
        check("mem_r_en", mem_r_en, issue && e_mr);
        check("mem_w_en", mem_w_en, issue && e_mw);
        check("b", b, issue && e_b);
        check("s", s, issue && e_s);
        check("imm", imm, issue && ib);
        check("exe_cmd", exe_cmd, issue ? e_cmd : 4'd0);
        check("dest", dest, issue ? rd_i : 4'd0);
        check("src1", src1, issue ? rn_i : 4'd0);
        check("src2", src2, issue ? sec : 4'd0);
        check("shift_operand", shift_operand, issue ? instruction[11:0] : 12'd0);
        check("signed_imm_24", signed_imm_24, issue ? instruction[23:0] : 24'd0);
        check("pc", pc, issue ? pc_in : 32'd0);
        check("val_rn", val_rn, issue ? e_vrn : 32'd0);
        check("val_rm", val_rm, issue ? e_vrm : 32'd0);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [3:0] f,
                         input bit fl, input bit ee, input logic [3:0] ed,
                         input bit me, input logic [3:0] md,
                         input bit we, input logic [3:0] wd, input logic [31:0] wv);
        instr_valid = v; instruction = ins; status_nzcv = f; flush = fl;
        exe_wb_en = ee; exe_dest = ed; mem_wb_en = me; mem_dest = md;
        wb_en_in = we; wb_dest = wd; wb_value = wv;
        pc_in = pc_in + 32'd4;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm}, 7'd0);
        check({tag, "_fld"}, {exe_cmd, dest, src1, src2, shift_operand, signed_imm_24}, 52'd0);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_vals"}, {val_rn, val_rm}, 64'd0);
    endtask

    localparam logic [31:0] ADD = 32'hE0821003;

    initial begin
        logic [31:0] r;
        logic [3:0]  cnd;

        foreach (cmd_tbl[k]) begin cmd_tbl[k] = 4'd0; wb_tbl[k] = 0; known_tbl[k] = 0; end
        cmd_tbl[13] = 4'd1; cmd_tbl[15] = 4'd9; cmd_tbl[4] = 4'd2; cmd_tbl[5] = 4'd3;
        cmd_tbl[2] = 4'd4;  cmd_tbl[6] = 4'd5;  cmd_tbl[0] = 4'd6; cmd_tbl[12] = 4'd7;
        cmd_tbl[1] = 4'd8;  cmd_tbl[10] = 4'd4; cmd_tbl[8] = 4'd6;
        foreach (wb_tbl[k]) wb_tbl[k] = (k == 13 || k == 15 || k == 4 || k == 5 || k == 2 ||
                                         k == 6 || k == 0 || k == 12 || k == 1);
        foreach (known_tbl[k]) known_tbl[k] = wb_tbl[k] || k == 10 || k == 8;
        foreach (regs[k]) regs[k] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Preload r2=5, r3=7, r5=0x1000 with no instruction in decode
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd2, 32'd5);      cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 32'd7);      cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 32'h1000);   cycle();

        // ADD r1,r2,r3
        drive(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);            cycle();
        check("add_vals", {val_rn, val_rm}, {32'd5, 32'd7});
        check("add_ctl", {out_valid, wb_en, exe_cmd, dest}, {1'b1, 1'b1, 4'b0010, 4'd1});

        // ADDEQ with Z clear then set; ADDGT with N=V=1, Z=0
        drive(1, 32'h00821003, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        drive(1, 32'h00821003, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        drive(1, 32'hC0821003, 4'b1001, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

        // EXE hazard on r2, then released
        drive(1, ADD, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0);         cycle();
        drive(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);            cycle();

        // STR r4,[r5] and LDR r4,[r5]
        drive(1, 32'hE5854000, 0, 0, 0, 0, 0, 0, 0, 0, 0);   cycle();
        drive(1, 32'hE5954000, 0, 0, 0, 0, 0, 0, 0, 0, 0);   cycle();

        // Write-back of r2 while ADD reads it
        drive(1, ADD, 0, 0, 0, 0, 0, 0, 1, 4'd2, 32'h55);    cycle();
        drive(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);            cycle();
        check("wb_read", val_rn, 32'h55);

        // Flush together with a MEM hazard
        drive(1, ADD, 0, 1, 0, 0, 1, 4'd3, 0, 0, 0);         cycle();

        // Randomized traffic with an asynchronous reset part way through
        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            cnd = ($urandom_range(0, 3) == 0) ? r[31:28] : 4'hE;
            r = $urandom();
            drive($urandom_range(0, 3) != 0, {cnd, r[27:0]}, 4'($urandom()),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, 4'($urandom()),
                  $urandom_range(0, 3) == 0, 4'($urandom()),
                  $urandom_range(0, 1) == 1, 4'($urandom()), $urandom());
            cycle();
            if (i == 300) begin
                drive(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                @(posedge clk);
                #2 rst = 1'b0;
                #1 check_all_zero("async_rst");
                foreach (regs[k]) regs[k] = '0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
